tri_bus_arbiter: RTL and testbench

// - Parametrised shared tri-state bus: NUM_MASTERS requesters share one DATA_W-wide tri bus.
// - Registered round-robin arbiter issues one-hot grants, bounds tenure to HOLD_MAX cycles,
//   and inserts one turnaround cycle (bus = Z) between owners so two drivers never overlap.
// - Sits between local masters and a shared tri bus; also returns a registered sample of the bus.
//

---
 rtl/tri_bus_arbiter_if.sv | 26 ++
 rtl/tri_bus_arbiter.sv | 114 +++++++++++
 tb/tb_tri_bus_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tri_bus_arbiter_if.sv
// Handshake bundle between local masters and the tri-state bus arbiter.
// The shared tri-state bus itself stays a plain inout net on the arbiter.
interface tri_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_W      = 8
);
  localparam int ID_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0]        req;
  logic [NUM_MASTERS*DATA_W-1:0] wdata;
  logic [NUM_MASTERS-1:0]        grant;
  logic [ID_W-1:0]               owner_id;
  logic                          bus_busy;
  logic [DATA_W-1:0]             rdata;
  logic                          rdata_valid;

  modport slave (
    input  req, wdata,
    output grant, owner_id, bus_busy, rdata, rdata_valid
  );

  modport master (
    output req, wdata,
    input  grant, owner_id, bus_busy, rdata, rdata_valid
  );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus with bounded tenure and a Z turnaround cycle.
// Optional BUS_KEEPER_EN: rdata holds the last driven value while the bus is idle.
module tri_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_MAX    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  tri_bus_arbiter_if.slave  bif,
  inout  wire [DATA_W-1:0]  bus
);

  localparam int ID_W = $clog2(NUM_MASTERS);
  localparam int HC_W = $clog2(HOLD_MAX + 1);
  localparam logic [HC_W-1:0] HOLD_MAX_C = HC_W'(HOLD_MAX);
  localparam logic [ID_W-1:0] LAST_IDX   = ID_W'(NUM_MASTERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_TURN} state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [ID_W-1:0]        r_owner_id;
  logic [ID_W-1:0]        r_last_owner;
  logic [HC_W-1:0]        r_hold_cnt;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_rdata_valid;

  logic                   w_rr_found;
  logic [ID_W-1:0]        w_rr_idx;
  logic [NUM_MASTERS-1:0] w_rr_onehot;
  logic                   w_owner_req;
  logic                   w_others_req;

  // Search begins just after the previous owner, so it is considered last.
  always_comb begin
    int cand;
    cand       = 0;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = (int'(r_last_owner) + k) % NUM_MASTERS;
      if (!w_rr_found && bif.req[cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = ID_W'(cand);
      end
    end
  end

  assign w_rr_onehot  = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_rr_idx;
  assign w_owner_req  = |(bif.req & r_grant);
  assign w_others_req = |(bif.req & ~r_grant);

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_drv
    assign bus = r_grant[i] ? bif.wdata[i*DATA_W +: DATA_W] : {DATA_W{1'bz}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_owner_id    <= '0;
      r_last_owner  <= LAST_IDX;
      r_hold_cnt    <= '0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= |r_grant;
`ifdef BUS_KEEPER_EN
      if (|r_grant) r_rdata <= bus;
`else
      r_rdata <= bus;
`endif
      case (r_state)
        S_IDLE, S_TURN: begin
          r_hold_cnt <= '0;
          if (w_rr_found) begin
            r_state      <= S_OWN;
            r_grant      <= w_rr_onehot;
            r_owner_id   <= w_rr_idx;
            r_last_owner <= w_rr_idx;
            r_hold_cnt   <= HC_W'(1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OWN: begin
          // A dropped request and an expired hold in the same cycle give one TURN.
          if (!w_owner_req || (r_hold_cnt == HOLD_MAX_C && w_others_req)) begin
            r_state    <= S_TURN;
            r_grant    <= '0;
            r_owner_id <= '0;
            r_hold_cnt <= '0;
          end else if (r_hold_cnt != HOLD_MAX_C) begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_grant    <= '0;
          r_owner_id <= '0;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  assign bif.grant       = r_grant;
  assign bif.owner_id    = r_owner_id;
  assign bif.bus_busy    = |r_grant;
  assign bif.rdata       = r_rdata;
  assign bif.rdata_valid = r_rdata_valid;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (NUM_MASTERS=4, DATA_W=8, HOLD_MAX=4).
module tb_tri_bus_arbiter;
  localparam int NM = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire [DW-1:0] bus;
  int n_pass = 0;
  int n_total = 0;

  tri_bus_arbiter_if #(.NUM_MASTERS(NM), .DATA_W(DW)) bif ();

  tri_bus_arbiter #(.NUM_MASTERS(NM), .DATA_W(DW), .HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bif   (bif),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] wd(input int i);
    return bif.wdata[i*DW +: DW];
  endfunction

  function automatic logic bus_shows_master();
    return (bus === wd(0)) || (bus === wd(1)) || (bus === wd(2)) || (bus === wd(3));
  endfunction

  task automatic set_wdata(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
    bif.wdata = {d, c, b, a};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bif.req = '0;
    set_wdata(8'h11, 8'h22, 8'h33, 8'h44);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (bif.grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", bif.grant); else n_pass++;
    n_total++; if (bif.owner_id !== 2'd0) $display("FAIL reset_owner: got %0d want 0", bif.owner_id); else n_pass++;
    n_total++; if (bif.bus_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bif.bus_busy); else n_pass++;
    n_total++; if (bif.rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", bif.rdata); else n_pass++;
    n_total++; if (bif.rdata_valid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", bif.rdata_valid); else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_total++; if (bif.grant !== 4'b0000) $display("FAIL idle_grant c%0d: got %b want 0000", c, bif.grant); else n_pass++;
      n_total++; if (bif.rdata_valid !== 1'b0) $display("FAIL idle_rvalid c%0d: got %b want 0", c, bif.rdata_valid); else n_pass++;
      n_total++; if (bus_shows_master()) $display("FAIL idle_bus c%0d: got %h want undriven", c, bus); else n_pass++;
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    bif.wdata[7:0] = 8'hA5;
    bif.req = 4'b0001;
    @(negedge clk);
    n_total++; if (bif.grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", bif.grant); else n_pass++;
    n_total++; if (bif.owner_id !== 2'd0) $display("FAIL single_owner: got %0d want 0", bif.owner_id); else n_pass++;
    n_total++; if (bif.bus_busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bif.bus_busy); else n_pass++;
    n_total++; if (bus !== 8'hA5) $display("FAIL single_bus: got %h want a5", bus); else n_pass++;
    @(negedge clk);
    n_total++; if (bif.rdata !== 8'hA5) $display("FAIL single_rdata: got %h want a5", bif.rdata); else n_pass++;
    n_total++; if (bif.rdata_valid !== 1'b1) $display("FAIL single_rvalid: got %b want 1", bif.rdata_valid); else n_pass++;
    bif.req = 4'b0000;
    @(negedge clk);
    n_total++; if (bif.grant !== 4'b0000) $display("FAIL single_release: got %b want 0000", bif.grant); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    set_wdata(8'h10, 8'h21, 8'h32, 8'h43);
    bif.req = 4'b1111;
    for (int m = 0; m < NM; m++) begin
      exp = 4'b0001 << m;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        n_total++; if (bif.grant !== exp) $display("FAIL rr_grant m%0d c%0d: got %b want %b", m, c, bif.grant, exp); else n_pass++;
        n_total++; if (bus !== wd(m)) $display("FAIL rr_bus m%0d c%0d: got %h want %h", m, c, bus, wd(m)); else n_pass++;
        n_total++; if (bif.owner_id !== 2'(m)) $display("FAIL rr_owner m%0d c%0d: got %0d want %0d", m, c, bif.owner_id, m); else n_pass++;
      end
      @(negedge clk);
      n_total++; if (bif.grant !== 4'b0000) $display("FAIL rr_turn m%0d: got %b want 0000", m, bif.grant); else n_pass++;
      n_total++; if (bus_shows_master()) $display("FAIL rr_turn_bus m%0d: got %h want undriven", m, bus); else n_pass++;
    end
    @(negedge clk);
    n_total++; if (bif.grant !== 4'b0001) $display("FAIL rr_wrap: got %b want 0001", bif.grant); else n_pass++;
    bif.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_alone();
    bif.req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_total++; if (bif.grant !== 4'b0100) $display("FAIL hold_grant c%0d: got %b want 0100", c, bif.grant); else n_pass++;
    end
    bif.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simul_expire();
    do_reset();
    bif.req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_total++; if (bif.grant !== 4'b0001) $display("FAIL simul_own c%0d: got %b want 0001", c, bif.grant); else n_pass++;
    end
    bif.req = 4'b0010;
    @(negedge clk);
    n_total++; if (bif.grant !== 4'b0000) $display("FAIL simul_turn: got %b want 0000", bif.grant); else n_pass++;
    @(negedge clk);
    n_total++; if (bif.grant !== 4'b0010) $display("FAIL simul_next: got %b want 0010", bif.grant); else n_pass++;
    bif.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    bif.req = 4'b0010;
    @(negedge clk);
    n_total++; if (bif.grant !== 4'b0010) $display("FAIL arst_pre: got %b want 0010", bif.grant); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (bif.grant !== 4'b0000) $display("FAIL arst_grant: got %b want 0000", bif.grant); else n_pass++;
    n_total++; if (bif.bus_busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", bif.bus_busy); else n_pass++;
    n_total++; if (bus_shows_master()) $display("FAIL arst_bus: got %h want undriven", bus); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bif.req = 4'b1111;
    @(negedge clk);
    n_total++; if (bif.grant !== 4'b0001) $display("FAIL arst_prio: got %b want 0001", bif.grant); else n_pass++;
    bif.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bus_keeper();
    set_wdata(8'h3C, 8'h11, 8'h22, 8'h33);
    bif.req = 4'b0001;
    @(negedge clk);
    n_total++; if (bus !== 8'h3C) $display("FAIL keep_bus: got %h want 3c", bus); else n_pass++;
    bif.req = 4'b0000;
    @(negedge clk);
    n_total++; if (bif.rdata !== 8'h3C) $display("FAIL keep_capture: got %h want 3c", bif.rdata); else n_pass++;
    n_total++; if (bif.rdata_valid !== 1'b1) $display("FAIL keep_rvalid1: got %b want 1", bif.rdata_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (bif.rdata_valid !== 1'b0) $display("FAIL keep_rvalid0: got %b want 0", bif.rdata_valid); else n_pass++;
`ifdef BUS_KEEPER_EN
    n_total++; if (bif.rdata !== 8'h3C) $display("FAIL keep_hold: got %h want 3c", bif.rdata); else n_pass++;
`else
    n_total++; if (bif.rdata === 8'h3C) $display("FAIL keep_idle: got %h want undriven sample", bif.rdata); else n_pass++;
`endif
  endtask

  initial begin
    bif.req = '0;
    bif.wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_alone();
    test_simul_expire();
    test_async_reset();
    test_bus_keeper();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
